// File: rtl/mix_columns_xor.sv
// Purpose: AES MixColumns on a 16-byte state, XORed with round key and mask; plus one Rcon key byte.
// Latency: 1 cycle, one result per cycle, back-to-back inputs accepted.
// Backpressure: none; in_valid only qualifies capture, outputs hold when in_valid is low.
module mix_columns_xor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] G0, input logic [7:0] G1, input logic [7:0] G2, input logic [7:0] G3,
    input  logic [7:0] G4, input logic [7:0] G5, input logic [7:0] G6, input logic [7:0] G7,
    input  logic [7:0] G8, input logic [7:0] G9, input logic [7:0] GA, input logic [7:0] GB,
    input  logic [7:0] GC, input logic [7:0] GD, input logic [7:0] GE, input logic [7:0] GF,
    input  logic [7:0] H0, input logic [7:0] H1, input logic [7:0] H2, input logic [7:0] H3,
    input  logic [7:0] H4, input logic [7:0] H5, input logic [7:0] H6, input logic [7:0] H7,
    input  logic [7:0] H8, input logic [7:0] H9, input logic [7:0] HA, input logic [7:0] HB,
    input  logic [7:0] HC, input logic [7:0] HD, input logic [7:0] HE, input logic [7:0] HF,
    input  logic [7:0] T0, input logic [7:0] T1, input logic [7:0] T2, input logic [7:0] T3,
    input  logic [7:0] T4, input logic [7:0] T5, input logic [7:0] T6, input logic [7:0] T7,
    input  logic [7:0] T8, input logic [7:0] T9, input logic [7:0] TA, input logic [7:0] TB,
    input  logic [7:0] TC, input logic [7:0] TD, input logic [7:0] TE, input logic [7:0] TF,
    input  logic [7:0] KC,
    input  logic [7:0] Rcon_in,
    output logic [7:0] R0, output logic [7:0] R1, output logic [7:0] R2, output logic [7:0] R3,
    output logic [7:0] R4, output logic [7:0] R5, output logic [7:0] R6, output logic [7:0] R7,
    output logic [7:0] R8, output logic [7:0] R9, output logic [7:0] RA, output logic [7:0] RB,
    output logic [7:0] RC, output logic [7:0] RD, output logic [7:0] RE, output logic [7:0] RF,
    output logic [7:0] KAC,
    output logic       out_valid
);

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by x+1 in GF(2^8).
    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Byte index i = 4*column + row throughout.
    logic [7:0] w_g [16];
    logic [7:0] w_h [16];
    logic [7:0] w_t [16];
    logic [7:0] w_r [16];
    logic [7:0] w_kac;

    logic [7:0] r_r [16];
    logic [7:0] r_kac;
    logic       r_out_valid;

    assign w_g = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF};
    assign w_h = '{H0, H1, H2, H3, H4, H5, H6, H7, H8, H9, HA, HB, HC, HD, HE, HF};
    assign w_t = '{T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, TA, TB, TC, TD, TE, TF};

    assign w_kac = KC ^ Rcon_in;

    // Per-column MixColumns, then fold in round key and mask byte-wise.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_r[4*c+0] = xtime(w_g[4*c+0]) ^ mul3(w_g[4*c+1]) ^ w_g[4*c+2] ^ w_g[4*c+3]
                       ^ w_h[4*c+0] ^ w_t[4*c+0];
            w_r[4*c+1] = w_g[4*c+0] ^ xtime(w_g[4*c+1]) ^ mul3(w_g[4*c+2]) ^ w_g[4*c+3]
                       ^ w_h[4*c+1] ^ w_t[4*c+1];
            w_r[4*c+2] = w_g[4*c+0] ^ w_g[4*c+1] ^ xtime(w_g[4*c+2]) ^ mul3(w_g[4*c+3])
                       ^ w_h[4*c+2] ^ w_t[4*c+2];
            w_r[4*c+3] = mul3(w_g[4*c+0]) ^ w_g[4*c+1] ^ w_g[4*c+2] ^ xtime(w_g[4*c+3])
                       ^ w_h[4*c+3] ^ w_t[4*c+3];
        end
    end

    // Output registers: capture on in_valid, otherwise hold; out_valid tracks last in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_r[i] <= 8'h00;
            end
            r_kac       <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 16; i++) begin
                    r_r[i] <= w_r[i];
                end
                r_kac <= w_kac;
            end
        end
    end

    assign R0 = r_r[0];   assign R1 = r_r[1];   assign R2 = r_r[2];   assign R3 = r_r[3];
    assign R4 = r_r[4];   assign R5 = r_r[5];   assign R6 = r_r[6];   assign R7 = r_r[7];
    assign R8 = r_r[8];   assign R9 = r_r[9];   assign RA = r_r[10];  assign RB = r_r[11];
    assign RC = r_r[12];  assign RD = r_r[13];  assign RE = r_r[14];  assign RF = r_r[15];

    assign KAC       = r_kac;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mix_columns_xor.sv
// Scoreboard bench for mix_columns_xor: driver pushes expected results, negedge monitor pops and compares.
// Reference model uses generic GF(2^8) multiply and the circulant MixColumns matrix.
module tb_mix_columns_xor;

    typedef struct packed {
        logic [127:0] r;
        logic [7:0]   kac;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] g_v = '0;
    logic [127:0] h_v = '0;
    logic [127:0] t_v = '0;
    logic [7:0]   kc = '0;
    logic [7:0]   rc = '0;

    logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, RA, RB, RC, RD, RE, RF;
    logic [7:0] KAC;
    logic       out_valid;
    logic [127:0] dut_r;

    exp_t q[$];
    exp_t last;
    bit   mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    assign dut_r = {RF, RE, RD, RC, RB, RA, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};

    always #5 clk = ~clk;

    mix_columns_xor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .G0(g_v[7:0]),     .G1(g_v[15:8]),    .G2(g_v[23:16]),   .G3(g_v[31:24]),
        .G4(g_v[39:32]),   .G5(g_v[47:40]),   .G6(g_v[55:48]),   .G7(g_v[63:56]),
        .G8(g_v[71:64]),   .G9(g_v[79:72]),   .GA(g_v[87:80]),   .GB(g_v[95:88]),
        .GC(g_v[103:96]),  .GD(g_v[111:104]), .GE(g_v[119:112]), .GF(g_v[127:120]),
        .H0(h_v[7:0]),     .H1(h_v[15:8]),    .H2(h_v[23:16]),   .H3(h_v[31:24]),
        .H4(h_v[39:32]),   .H5(h_v[47:40]),   .H6(h_v[55:48]),   .H7(h_v[63:56]),
        .H8(h_v[71:64]),   .H9(h_v[79:72]),   .HA(h_v[87:80]),   .HB(h_v[95:88]),
        .HC(h_v[103:96]),  .HD(h_v[111:104]), .HE(h_v[119:112]), .HF(h_v[127:120]),
        .T0(t_v[7:0]),     .T1(t_v[15:8]),    .T2(t_v[23:16]),   .T3(t_v[31:24]),
        .T4(t_v[39:32]),   .T5(t_v[47:40]),   .T6(t_v[55:48]),   .T7(t_v[63:56]),
        .T8(t_v[71:64]),   .T9(t_v[79:72]),   .TA(t_v[87:80]),   .TB(t_v[95:88]),
        .TC(t_v[103:96]),  .TD(t_v[111:104]), .TE(t_v[119:112]), .TF(t_v[127:120]),
        .KC(kc), .Rcon_in(rc),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .R8(R8), .R9(R9), .RA(RA), .RB(RB), .RC(RC), .RD(RD), .RE(RE), .RF(RF),
        .KAC(KAC), .out_valid(out_valid)
    );

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       carry;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            carry = aa[7];
            aa    = {aa[6:0], 1'b0};
            if (carry) aa = aa ^ 8'h1B;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Circulant MixColumns matrix: row r of [2 3 1 1] rotated right by r.
    function automatic logic [7:0] coef(input int r, input int k);
        case ((k - r) & 3)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic exp_t model(input logic [127:0] gv, input logic [127:0] hv,
                                   input logic [127:0] tv, input logic [7:0] k, input logic [7:0] rcn);
        exp_t       e;
        logic [7:0] acc;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k2 = 0; k2 < 4; k2++) begin
                    acc = acc ^ gmul(coef(r, k2), gv[8*(4*c+k2) +: 8]);
                end
                e.r[8*(4*c+r) +: 8] = acc ^ hv[8*(4*c+r) +: 8] ^ tv[8*(4*c+r) +: 8];
            end
        end
        e.kac = k ^ rcn;
        return e;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle; a valid cycle's expected result becomes visible after the edge.
    task automatic cycle_push(input logic v, input exp_t e);
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) q.push_back(e);
    endtask

    // Monitor: out_valid must match a pending result; otherwise outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            check("out_valid", {127'b0, out_valid}, {127'b0, (q.size() != 0)});
            if (out_valid === 1'b1 && q.size() != 0) begin
                e = q.pop_front();
                check("R", dut_r, e.r);
                check("KAC", {120'b0, KAC}, {120'b0, e.kac});
                last = e;
            end else if (out_valid === 1'b0) begin
                check("R_hold", dut_r, last.r);
                check("KAC_hold", {120'b0, KAC}, {120'b0, last.kac});
            end
        end
    end

    initial begin
        exp_t e;
        logic v;
        last = '0;

        // Initial asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_R", dut_r, 128'h0);
        check("reset_KAC", {120'b0, KAC}, 128'h0);
        check("reset_out_valid", {127'b0, out_valid}, 128'h0);
        #13 rst_n = 1'b1;
        mon_en = 1'b1;

        // Standard column vector.
        g_v = 128'h0; g_v[31:0] = 32'h4553_13DB; h_v = '0; t_v = '0; kc = 8'h00; rc = 8'h00;
        e.r = 128'h0; e.r[31:0] = 32'hBCA1_4D8E; e.kac = 8'h00;
        cycle_push(1'b1, e);

        // xtime reduction, back-to-back with the previous vector.
        g_v = 128'h0; g_v[31:0] = 32'h8080_8080;
        e.r = 128'h0; e.r[31:0] = 32'h8080_8080; e.kac = 8'h00;
        cycle_push(1'b1, e);

        // Key XOR: G = H = 00..0F, no mask.
        g_v = 128'h0F0E0D0C_0B0A0908_07060504_03020100; h_v = g_v; t_v = '0;
        e.r = 128'h06020602_06020602_06020602_06020602; e.kac = 8'h00;
        cycle_push(1'b1, e);

        // Hold: idle cycles with different data on the inputs.
        g_v = {4{32'hDEADBEEF}}; h_v = {4{32'h12345678}}; kc = 8'h55; rc = 8'hAA;
        cycle_push(1'b0, '0);
        cycle_push(1'b0, '0);

        // Mask cancel: G = H = T = 00..0F.
        g_v = 128'h0F0E0D0C_0B0A0908_07060504_03020100; h_v = g_v; t_v = g_v;
        kc = 8'h0C; rc = 8'h36;
        e.r = 128'h090C0B0E_0D080F0A_01040306_05000702; e.kac = 8'h3A;
        cycle_push(1'b1, e);
        in_valid = 1'b0;

        // Mid-stream reset: outputs are nonzero, must clear without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_R", dut_r, 128'h0);
        check("midreset_KAC", {120'b0, KAC}, 128'h0);
        check("midreset_out_valid", {127'b0, out_valid}, 128'h0);
        q.delete();
        last = '0;
        #3 rst_n = 1'b1;

        // First valid input after reset gives a normal result.
        g_v = {$urandom, $urandom, $urandom, $urandom};
        h_v = {$urandom, $urandom, $urandom, $urandom};
        t_v = '0; kc = 8'(($urandom)); rc = 8'h01;
        cycle_push(1'b1, model(g_v, h_v, t_v, kc, rc));

        // Randomized traffic with random valid gaps.
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            g_v = {$urandom, $urandom, $urandom, $urandom};
            h_v = {$urandom, $urandom, $urandom, $urandom};
            t_v = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom, $urandom, $urandom} : 128'h0;
            kc  = 8'($urandom);
            rc  = 8'($urandom);
            cycle_push(v, model(g_v, h_v, t_v, kc, rc));
        end

        for (int i = 0; i < 3; i++) cycle_push(1'b0, '0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 128'(q.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
